// File: rtl/buffer_stream.sv
// buffer_stream: byte-addressable on-chip buffer with byte/word host access
// and an autonomous valid/ready byte-stream read engine.
// Optional feature macro: BUFFER_STREAM_WRAP_EN (stream address wraps modulo
// BuffDepth; otherwise a stream is clipped at the top of the buffer).
module buffer_stream #(
  parameter int unsigned BuffDepth = 256,
  parameter int unsigned WordBytes = 8,
  parameter int unsigned ByteAddrW = $clog2(BuffDepth),
  parameter int unsigned WordAddrW = $clog2(BuffDepth / WordBytes)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_en,
  input  logic                   read_en,
  input  logic                   addr_mode,
  input  logic [ByteAddrW-1:0]   byte_addr,
  input  logic [WordAddrW-1:0]   word_addr,
  input  logic [7:0]             byte_in,
  input  logic [8*WordBytes-1:0] word_in,
  input  logic [WordBytes-1:0]   word_be,
  output logic [7:0]             byte_out,
  output logic [8*WordBytes-1:0] word_out,
  output logic                   rd_valid,
  input  logic                   strm_start,
  input  logic [ByteAddrW-1:0]   strm_base,
  input  logic [ByteAddrW:0]     strm_len,
  output logic [7:0]             strm_data,
  output logic                   strm_valid,
  input  logic                   strm_ready,
  output logic                   strm_last,
  output logic                   strm_busy
);

  localparam int unsigned LenW  = ByteAddrW + 1;
  localparam int unsigned WordW = 8 * WordBytes;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  logic [7:0] mem_q [BuffDepth];

  logic [7:0]           byte_out_q;
  logic [WordW-1:0]     word_out_q;
  logic                 rd_valid_q;

  state_e               state_q, state_d;
  logic [ByteAddrW-1:0] addr_q, addr_d;
  logic [LenW-1:0]      remain_q, remain_d;
  logic [7:0]           sdata_q, sdata_d;
  logic                 svalid_q, svalid_d;
  logic                 slast_q, slast_d;
  logic                 sbusy_q, sbusy_d;

  logic [LenW-1:0]      room_c;
  logic [LenW-1:0]      eff_len_c;
  logic [ByteAddrW-1:0] next_addr_c;

  // Byte address of lane k inside word wa (little-endian layout).
  function automatic logic [ByteAddrW-1:0] lane_addr(input logic [WordAddrW-1:0] wa,
                                                     input int unsigned k);
    return ByteAddrW'((32'(wa) * WordBytes) + k);
  endfunction

  // Storage array: byte or byte-enabled word writes, contents never reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      if (!addr_mode) begin
        mem_q[byte_addr] <= byte_in;
      end else begin
        for (int unsigned k = 0; k < WordBytes; k++) begin
          if (word_be[k]) mem_q[lane_addr(word_addr, k)] <= word_in[8*k +: 8];
        end
      end
    end
  end

  // Host read port: registered data, only the accessed width updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_out_q <= 8'h00;
      word_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= read_en;
      if (read_en) begin
        if (!addr_mode) begin
          byte_out_q <= mem_q[byte_addr];
        end else begin
          for (int unsigned k = 0; k < WordBytes; k++) begin
            word_out_q[8*k +: 8] <= mem_q[lane_addr(word_addr, k)];
          end
        end
      end
    end
  end

  // Effective stream length: capped at the buffer size, or at the top of the buffer.
  always_comb begin
`ifdef BUFFER_STREAM_WRAP_EN
    room_c = LenW'(BuffDepth);
`else
    room_c = LenW'(BuffDepth) - LenW'(strm_base);
`endif
    eff_len_c   = (strm_len < room_c) ? strm_len : room_c;
    next_addr_c = addr_q + ByteAddrW'(1);
  end

  // Stream engine next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    sdata_d  = sdata_q;
    case (state_q)
      S_IDLE: begin
        if (strm_start && (strm_len != '0)) begin
          state_d  = S_RUN;
          addr_d   = strm_base;
          remain_d = eff_len_c;
          sdata_d  = mem_q[strm_base];
        end
      end
      S_RUN: begin
        if (strm_ready) begin
          if (remain_q == LenW'(1)) begin
            state_d  = S_IDLE;
            remain_d = '0;
          end else begin
            addr_d   = next_addr_c;
            remain_d = remain_q - LenW'(1);
            sdata_d  = mem_q[next_addr_c];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    svalid_d = (state_d == S_RUN);
    sbusy_d  = (state_d == S_RUN);
    slast_d  = (state_d == S_RUN) && (remain_d == LenW'(1));
  end

  // Stream engine state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      sdata_q  <= 8'h00;
      svalid_q <= 1'b0;
      slast_q  <= 1'b0;
      sbusy_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      sdata_q  <= sdata_d;
      svalid_q <= svalid_d;
      slast_q  <= slast_d;
      sbusy_q  <= sbusy_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign word_out   = word_out_q;
  assign rd_valid   = rd_valid_q;
  assign strm_data  = sdata_q;
  assign strm_valid = svalid_q;
  assign strm_last  = slast_q;
  assign strm_busy  = sbusy_q;

endmodule

// File: tb/tb_buffer_stream.sv
// Testbench for buffer_stream (default parameters). Reference model keeps a
// byte array and a queue of pending stream addresses.
module tb_buffer_stream;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en, read_en, addr_mode;
  logic [7:0]  byte_addr;
  logic [4:0]  word_addr;
  logic [7:0]  byte_in;
  logic [63:0] word_in;
  logic [7:0]  word_be;
  logic [7:0]  byte_out;
  logic [63:0] word_out;
  logic        rd_valid;
  logic        strm_start;
  logic [7:0]  strm_base;
  logic [8:0]  strm_len;
  logic [7:0]  strm_data;
  logic        strm_valid, strm_ready, strm_last, strm_busy;

  buffer_stream dut (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
    .addr_mode(addr_mode), .byte_addr(byte_addr), .word_addr(word_addr),
    .byte_in(byte_in), .word_in(word_in), .word_be(word_be),
    .byte_out(byte_out), .word_out(word_out), .rd_valid(rd_valid),
    .strm_start(strm_start), .strm_base(strm_base), .strm_len(strm_len),
    .strm_data(strm_data), .strm_valid(strm_valid), .strm_ready(strm_ready),
    .strm_last(strm_last), .strm_busy(strm_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0]  ref_mem [DEPTH];
  int          m_addrs [$];
  logic        m_busy;
  logic [7:0]  m_data;
  logic        m_rd_valid;
  logic [7:0]  m_byte;
  logic [63:0] m_word;
  logic [7:0]  got [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    chk("byte_out", 64'(byte_out), 64'(m_byte));
    chk("word_out", word_out, m_word);
    chk("strm_valid", 64'(strm_valid), 64'(m_busy));
    chk("strm_busy", 64'(strm_busy), 64'(m_busy));
    chk("strm_last", 64'(strm_last), 64'(m_busy && (m_addrs.size() == 1)));
    if (m_busy) chk("strm_data", 64'(strm_data), 64'(m_data));
  endtask

  task automatic idle_inputs();
    write_en = 0; read_en = 0; addr_mode = 0; byte_addr = 0; word_addr = 0;
    byte_in = 0; word_in = 0; word_be = 0; strm_start = 0; strm_base = 0;
    strm_len = 0; strm_ready = 0;
  endtask

  // Advance one clock: update the model for the coming edge, then check at negedge.
  task automatic tick();
    int n, base, len;
    if (strm_valid && strm_ready) got.push_back(strm_data);
    // stream side sees memory contents from before this edge's write
    if (m_busy) begin
      if (strm_ready) begin
        void'(m_addrs.pop_front());
        if (m_addrs.size() == 0) m_busy = 1'b0;
        else m_data = ref_mem[m_addrs[0]];
      end
    end else if (strm_start && strm_len != 0) begin
      base = int'(strm_base);
      len  = int'(strm_len);
`ifdef BUFFER_STREAM_WRAP_EN
      n = (len < DEPTH) ? len : DEPTH;
      for (int i = 0; i < n; i++) m_addrs.push_back((base + i) % DEPTH);
`else
      n = (len < DEPTH - base) ? len : DEPTH - base;
      for (int i = 0; i < n; i++) m_addrs.push_back(base + i);
`endif
      m_busy = 1'b1;
      m_data = ref_mem[m_addrs[0]];
    end
    m_rd_valid = read_en;
    if (read_en) begin
      if (!addr_mode) m_byte = ref_mem[byte_addr];
      else for (int k = 0; k < 8; k++) m_word[8*k +: 8] = ref_mem[int'(word_addr)*8 + k];
    end
    if (write_en) begin
      if (!addr_mode) ref_mem[byte_addr] = byte_in;
      else for (int k = 0; k < 8; k++)
        if (word_be[k]) ref_mem[int'(word_addr)*8 + k] = word_in[8*k +: 8];
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_model();
    m_addrs.delete();
    m_busy = 0; m_data = 0; m_rd_valid = 0; m_byte = 0; m_word = 0;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    clear_model();
    check_outputs();
    chk("rst_strm_data", 64'(strm_data), 64'd0);
    idle_inputs();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    got.delete();
  endtask

  task automatic run_stream(input int base, input int len);
    got.delete();
    strm_start = 1; strm_base = 8'(base); strm_len = 9'(len); strm_ready = 1;
    tick();
    strm_start = 0;
  endtask

  logic [7:0] prior [4];
  int         exp_n;

  initial begin
    idle_inputs();
    clear_model();
    rst = 1'b1;
    #3;
    check_outputs();
    chk("rst_strm_data", 64'(strm_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // fill the whole buffer with known random words
    for (int w = 0; w < DEPTH/8; w++) begin
      write_en = 1; addr_mode = 1; word_addr = 5'(w); word_be = 8'hFF;
      word_in = {$urandom, $urandom};
      tick();
    end
    idle_inputs();

    // byte write then word read of word 0
    write_en = 1; byte_addr = 8'd7; byte_in = 8'hFF; tick();
    idle_inputs(); read_en = 1; addr_mode = 1; word_addr = 0; tick();
    chk("t1_word_msb", 64'(word_out[63:56]), 64'hFF);
    chk("t1_rdv_high", 64'(rd_valid), 64'd1);
    idle_inputs(); tick();
    chk("t1_rdv_drop", 64'(rd_valid), 64'd0);

    // partial word write to word 2, then byte reads 16..23
    for (int i = 0; i < 4; i++) prior[i] = ref_mem[20 + i];
    write_en = 1; addr_mode = 1; word_addr = 5'd2; word_be = 8'h0F;
    word_in = 64'h0807060504030201; tick();
    idle_inputs();
    for (int i = 16; i < 24; i++) begin
      read_en = 1; byte_addr = 8'(i); tick();
      if (i < 20) chk("t2_low_lanes", 64'(byte_out), 64'(i - 15));
      else chk("t2_high_lanes", 64'(byte_out), 64'(prior[i - 20]));
    end
    idle_inputs();

    // stream base 16 len 4, ready held high
    run_stream(16, 4);
    chk("t3_first", 64'(strm_data), 64'h01);
    for (int i = 0; i < 4; i++) tick();
    chk("t3_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < got.size(); i++) chk("t3_byte", 64'(got[i]), 64'(i + 1));
    chk("t3_busy_fall", 64'(strm_busy), 64'd0);

    // same stream with a 3-cycle stall after byte 02 and an ignored start
    run_stream(16, 4);
    tick();
    strm_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin strm_start = 1; strm_base = 8'd0; strm_len = 9'd5; end
      tick();
      strm_start = 0;
      chk("t4_hold_data", 64'(strm_data), 64'h02);
      chk("t4_hold_valid", 64'(strm_valid), 64'd1);
    end
    strm_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < got.size(); i++) chk("t4_byte", 64'(got[i]), 64'(i + 1));

    // stream across the top of the buffer
    run_stream(254, 4);
    for (int i = 0; i < 5; i++) tick();
`ifdef BUFFER_STREAM_WRAP_EN
    exp_n = 4;
`else
    exp_n = 2;
`endif
    chk("t5_count", 64'(got.size()), 64'(exp_n));
    for (int i = 0; i < got.size() && i < exp_n; i++)
      chk("t5_byte", 64'(got[i]), 64'(ref_mem[(254 + i) % DEPTH]));

    // reset during a stream and a host read, then a 1-byte stream
    run_stream(0, 200);
    tick(); tick();
    read_en = 1; addr_mode = 1; word_addr = 5'd3;
    pulse_reset();
    run_stream(0, 1);
    chk("t6_last", 64'(strm_last), 64'd1);
    tick(); tick();
    chk("t6_count", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("t6_byte", 64'(got[0]), 64'(ref_mem[0]));

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      write_en   = ($urandom_range(0, 3) == 0);
      read_en    = ($urandom_range(0, 2) == 0);
      addr_mode  = 1'($urandom);
      byte_addr  = 8'($urandom);
      word_addr  = 5'($urandom);
      byte_in    = 8'($urandom);
      word_in    = {$urandom, $urandom};
      word_be    = 8'($urandom);
      strm_start = ($urandom_range(0, 7) == 0);
      strm_base  = 8'($urandom);
      strm_len   = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom_range(1, 300));
      strm_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/buffer_stream.md
# buffer_stream

Parametrised successor to the 64-bit byte/word buffer. It provides a byte-addressable on-chip buffer with configurable word width, byte-enabled word writes and registered host reads. It adds an autonomous byte-stream read engine with valid/ready handshake, which feeds the accelerator datapath from a base address and length. The block sits between the host load path, which writes weights and activations, and the compute array, which consumes the byte stream.

## Interface
Parameters:
- `BuffDepth`, 256: buffer size in bytes; power of two, ≥ 2·`WordBytes`.
- `WordBytes`, 8: bytes per word; power of two.
- `ByteAddrW`, $clog2(BuffDepth): byte address width (derived).
- `WordAddrW`, $clog2(BuffDepth/WordBytes): word address width (derived).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `write_en`  in  1  host write strobe.
- `read_en`  in  1  host read strobe.
- `addr_mode`  in  1  0 = byte access, 1 = word access.
- `byte_addr`  in  ByteAddrW  byte address (addr_mode 0).
- `word_addr`  in  WordAddrW  word address (addr_mode 1).
- `byte_in`  in  8  byte write data.
- `word_in`  in  8·WordBytes  word write data.
- `word_be`  in  WordBytes  byte enables for word writes.
- `byte_out`  out  8  registered byte read data.
- `word_out`  out  8·WordBytes  registered word read data.
- `rd_valid`  out  1  one-cycle pulse: read data updated.
- `strm_start`  in  1  start a stream (accepted only when idle).
- `strm_base`  in  ByteAddrW  stream start byte address.
- `strm_len`  in  ByteAddrW+1  stream byte count; 0 = no-op.
- `strm_data`  out  8  stream byte.
- `strm_valid`  out  1  strm_data valid.
- `strm_ready`  in  1  consumer accepts.
- `strm_last`  out  1  final byte of the stream.
- `strm_busy`  out  1  engine not idle.

## Operation
- Layout is little-endian. Byte k of word w is at byte address w·WordBytes+k and maps to `word_in`/`word_out`[8k+7:8k].
- Writes:
  - Byte mode writes `byte_in` at `byte_addr`.
  - Word mode writes only the lanes whose `word_be` bit is set.
  - Memory contents are not reset.
- Host reads:
  - Byte mode updates only `byte_out`; word mode updates only `word_out`.
  - The other output holds its value.
  - Outputs hold their value when `read_en` is 0.
- Simultaneous read and write are both performed. A read of an address written in the same cycle returns the old data.
- Stream FSM has two states, IDLE and RUN:
  - IDLE → RUN on `strm_start` with `strm_len` ≠ 0. The engine latches the base address and a remaining count, and loads mem[base] into `strm_data`.
  - `strm_start` is ignored in RUN, and also when `strm_len` = 0.
  - In RUN, on `strm_valid`&`strm_ready`: the address increments, the count decrements, and the next byte loads.
  - RUN → IDLE on the handshake of the byte with `strm_last`=1. `strm_valid` is 0 on the following cycle.
  - `strm_last` = `strm_valid` & (remaining = 1).
- Host and stream reads are independent ports, so host reads are allowed during RUN. A host write landing on the same edge as a stream fetch of that address yields old data to the stream.

## Timing
- Reset values are 0 for every output: `byte_out`, `word_out`, `rd_valid`, `strm_data`, `strm_valid`, `strm_last`, `strm_busy`. FSM resets to IDLE.
- Reset asserted mid-stream aborts the stream immediately (asynchronous). No byte is handshaken after reset.
- Host read latency is 1 cycle: `rd_valid` is high the cycle after `read_en`.
- Stream latency: first byte is valid the cycle after `strm_start`. Throughput is one byte per cycle while `strm_ready`=1.
- With `strm_ready`=0, `strm_data`, `strm_valid` and `strm_last` are held stable.
- `strm_busy` = (state = RUN).
- A new `strm_start` is accepted no earlier than the cycle after the final byte's handshake, i.e. when `strm_busy`=0.

## Configuration
- `BUFFER_STREAM_WRAP_EN` defined:
  - Stream address wraps modulo `BuffDepth`.
  - Effective length is `strm_len` capped at `BuffDepth`.
- Undefined:
  - Effective length = min(`strm_len`, `BuffDepth`−`strm_base`).
  - The stream never crosses the top of the buffer; `strm_last` asserts on byte address `BuffDepth`−1 at the latest.

## Test plan
1. Byte write 8'hFF at address 7, then word read of word 0 → `word_out`[63:56]=8'hFF, `rd_valid` high for exactly the cycle after `read_en`.
2. Word write 64'h0807060504030201 with `word_be`=8'h0F to word 2 → byte reads of addresses 16..19 return 01..04; addresses 20..23 unchanged from their prior contents.
3. Stream base 16, len 4, `strm_ready`=1 → `strm_data` 01,02,03,04 on 4 consecutive cycles starting 1 cycle after start. `strm_last` only on 04; `strm_busy` falls the next cycle.
4. Same stream with `strm_ready` low for 3 cycles after byte 02 → 02 held stable with `strm_valid`=1 throughout; all 4 bytes delivered with no loss or duplication. A `strm_start` issued during the stall is ignored.
5. Base 254, len 4:
   - With `BUFFER_STREAM_WRAP_EN`: bytes at addresses 254,255,0,1 are delivered.
   - Without it: 2 bytes, `strm_last` on address 255.
6. `rst` pulsed during a stream and during a host read → all outputs 0 immediately. After release, a new stream base 0, len 1 completes normally.
